intersection_traffic_model: RTL

- Closed-loop companion to the traffic light controller: consumes the five light colours, models a car queue per lane, and drives the five traffic sensors back into the controller.
- Also a protocol monitor: flags conflicting greens, illegal colour sequences, queue overflow and lane starvation.
- Sits in the top-level testbench and FPGA demo wrapper, directly across the controller's sensor/light interface.

---
 rtl/light_package.sv | 37 +++
 rtl/intersection_traffic_model_lane_queue.sv | 89 ++++++++
 rtl/intersection_traffic_model.sv | 107 ++++++++++
 3 files changed

// File: rtl/light_package.sv
// Shared light colours, lane indices and legal green-phase masks for the
// intersection model and its lane queues.
package light_package;

    typedef enum logic [1:0] {
        red    = 2'd0,
        yellow = 2'd1,
        green  = 2'd2
    } colors;

    localparam int unsigned NUM_LANES = 5;

    localparam int unsigned L_ES = 0;
    localparam int unsigned L_WS = 1;
    localparam int unsigned L_EL = 2;
    localparam int unsigned L_WL = 3;
    localparam int unsigned L_NS = 4;

    localparam logic [NUM_LANES-1:0] PHASE_ES_WS = 5'b00011;
    localparam logic [NUM_LANES-1:0] PHASE_EL_ES = 5'b00101;
    localparam logic [NUM_LANES-1:0] PHASE_WL_WS = 5'b01010;
    localparam logic [NUM_LANES-1:0] PHASE_WL_EL = 5'b01100;
    localparam logic [NUM_LANES-1:0] PHASE_NS    = 5'b10000;

    // A non-red set is legal if empty or contained in one of the phase masks.
    function automatic logic phase_legal(input logic [NUM_LANES-1:0] nonred);
        logic ok;
        ok = (nonred == '0);
        if ((nonred & ~PHASE_ES_WS) == '0) ok = 1'b1;
        if ((nonred & ~PHASE_EL_ES) == '0) ok = 1'b1;
        if ((nonred & ~PHASE_WL_WS) == '0) ok = 1'b1;
        if ((nonred & ~PHASE_WL_EL) == '0) ok = 1'b1;
        if ((nonred & ~PHASE_NS)    == '0) ok = 1'b1;
        return ok;
    endfunction

endpackage

// File: rtl/intersection_traffic_model_lane_queue.sv
// One lane of the intersection: car queue, departure pacing, starvation
// timer and colour-sequence checking for a single light.
module lane_queue
    import light_package::*;
#(
    parameter int unsigned CW           = 4,
    parameter int unsigned DEPART_GAP   = 2,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive,
    input  colors         light,
    output logic [CW-1:0] count,
    output logic          depart_c,
    output logic          overflow_c,
    output logic          starve_c,
    output logic          seq_err_c
);

    localparam int unsigned GW = 4;
    localparam int unsigned WW = 10;
    localparam logic [CW-1:0] MAX_Q = {CW{1'b1}};

    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [WW-1:0] wait_q, wait_d;
    colors         prev_q, prev_d;

    logic has_cars;
    logic room;
    logic arrival_ok;

    always_comb begin
        depart_c   = 1'b0;
        overflow_c = 1'b0;
        starve_c   = 1'b0;
        seq_err_c  = 1'b0;
        gap_d      = '0;
        wait_d     = '0;
        prev_d     = light;
        has_cars   = (count_q != '0);

        if (light == green && has_cars) begin
            if (gap_q == GW'(DEPART_GAP - 1)) begin
                depart_c = 1'b1;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end

        // A departing car frees its slot on the same edge, so a full lane
        // still accepts an arrival while it is draining.
        room       = (count_q != MAX_Q) || depart_c;
        arrival_ok = arrive && room;
        overflow_c = arrive && !room;
        count_d    = count_q + CW'(arrival_ok) - CW'(depart_c);

        if (light == red && has_cars) begin
            if (wait_q == WW'(STARVE_LIMIT)) begin
                wait_d = wait_q;
            end else begin
                wait_d = wait_q + WW'(1);
            end
            starve_c = (wait_q == WW'(STARVE_LIMIT - 1));
        end

        seq_err_c = (prev_q == green  && light == red)    ||
                    (prev_q == red    && light == yellow) ||
                    (prev_q == yellow && light == green);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            gap_q   <= '0;
            wait_q  <= '0;
            prev_q  <= red;
        end else begin
            count_q <= count_d;
            gap_q   <= gap_d;
            wait_q  <= wait_d;
            prev_q  <= prev_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/intersection_traffic_model.sv
// Closed-loop intersection model and protocol monitor sitting across the
// traffic-light controller's light/sensor interface.
module intersection_traffic_model
    import light_package::*;
#(
    parameter int unsigned CW           = 4,
    parameter int unsigned DEPART_GAP   = 2,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_LANES-1:0]   arrive,
    input  colors                  e_str_light,
    input  colors                  w_str_light,
    input  colors                  e_left_light,
    input  colors                  w_left_light,
    input  colors                  ns_light,
    output logic                   e_str_sensor,
    output logic                   w_str_sensor,
    output logic                   e_left_sensor,
    output logic                   w_left_sensor,
    output logic                   ns_sensor,
    output logic [NUM_LANES*CW-1:0] q_counts,
    output logic [15:0]            total_departed,
    output logic                   conflict_err,
    output logic                   seq_err,
    output logic                   overflow_err,
    output logic                   starve_err
);

    colors                lights [NUM_LANES];
    logic [CW-1:0]        counts [NUM_LANES];
    logic [NUM_LANES-1:0] depart_c, overflow_c, starve_c, seq_err_c, nonred_c;

    assign lights[L_ES] = e_str_light;
    assign lights[L_WS] = w_str_light;
    assign lights[L_EL] = e_left_light;
    assign lights[L_WL] = w_left_light;
    assign lights[L_NS] = ns_light;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_queue #(
            .CW          (CW),
            .DEPART_GAP  (DEPART_GAP),
            .STARVE_LIMIT(STARVE_LIMIT)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .arrive    (arrive[i]),
            .light     (lights[i]),
            .count     (counts[i]),
            .depart_c  (depart_c[i]),
            .overflow_c(overflow_c[i]),
            .starve_c  (starve_c[i]),
            .seq_err_c (seq_err_c[i])
        );
        assign q_counts[i*CW +: CW] = counts[i];
        assign nonred_c[i]          = (lights[i] != red);
    end

    assign e_str_sensor  = (counts[L_ES] != '0);
    assign w_str_sensor  = (counts[L_WS] != '0);
    assign e_left_sensor = (counts[L_EL] != '0);
    assign w_left_sensor = (counts[L_WL] != '0);
    assign ns_sensor     = (counts[L_NS] != '0);

    logic [15:0] total_q, total_d, dep_sum;
    logic        conflict_q, conflict_d;
    logic        seq_q, seq_d;
    logic        overflow_q, overflow_d;
    logic        starve_q, starve_d;

    always_comb begin
        dep_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            dep_sum = dep_sum + 16'(depart_c[i]);
        end
        total_d    = total_q + dep_sum;
        conflict_d = conflict_q | !phase_legal(nonred_c);
        seq_d      = seq_q      | (|seq_err_c);
        overflow_d = overflow_q | (|overflow_c);
        starve_d   = starve_q   | (|starve_c);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            total_q    <= '0;
            conflict_q <= 1'b0;
            seq_q      <= 1'b0;
            overflow_q <= 1'b0;
            starve_q   <= 1'b0;
        end else begin
            total_q    <= total_d;
            conflict_q <= conflict_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            starve_q   <= starve_d;
        end
    end

    assign total_departed = total_q;
    assign conflict_err   = conflict_q;
    assign seq_err        = seq_q;
    assign overflow_err   = overflow_q;
    assign starve_err     = starve_q;

endmodule
